// File: rtl/macro_15_pad_alu_resp.sv
// macro_15 dual-ALU pad responder: synchronises the operand/opcode word from
// the upper pads, waits until it has been stable long enough, then drives two
// registered 4-bit ALU results plus status back onto the lower pads.
module macro_15_pad_alu_resp #(
    parameter int unsigned STABLE_CYCLES = 4,   // legal 1..255
    parameter int unsigned SYNC_STAGES   = 2    // legal 2..3
) (
    input  logic        wb_clk_i,
    input  logic        resetb,
    input  logic [37:0] io_in,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb
);

    localparam int unsigned W_IO   = 38;
    localparam int unsigned W_WORD = 20;
    localparam int unsigned W_CNT  = 8;
    localparam int unsigned W_RES  = 5;
    localparam int unsigned W_FRM  = 2;

    localparam logic [W_IO-1:0]  OEB_MAP  = 38'h3F_FFFC_000E;
    localparam logic [W_CNT:0]   STABLE_N = (W_CNT+1)'(STABLE_CYCLES);
    localparam logic [W_CNT-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    // One ALU lane: ADD with carry, SUB with borrow, AND, XOR
    function automatic logic [W_RES-1:0] lane_alu(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic [1:0] sel
    );
        logic [W_RES-1:0] res;
        case (sel)
            2'b00:   res = {1'b0, a} + {1'b0, b};
            2'b01:   res = {(a < b), 4'(a - b)};
            2'b10:   res = {1'b0, a & b};
            default: res = {1'b0, a ^ b};
        endcase
        return res;
    endfunction

    logic [W_WORD-1:0] r_sync [SYNC_STAGES];
    logic [W_WORD-1:0] r_cand;
    logic [W_CNT-1:0]  r_cnt;
    state_t            r_state;
    logic [W_RES-1:0]  r_r0;
    logic [W_RES-1:0]  r_r1;
    logic              r_z0;
    logic              r_z1;
    logic [W_FRM-1:0]  r_frm;
    logic              r_valid;

    logic [W_WORD-1:0] w_s;
    logic              w_same;
    logic [W_CNT:0]    w_cnt_inc;
    logic              w_settled;
    logic [W_RES-1:0]  w_r0;
    logic [W_RES-1:0]  w_r1;
    logic              w_unused_io;

    // Pad bits [17:0] are outputs or unused inputs on this macro
    assign w_unused_io = ^io_in[17:0];

    // Input word synchroniser
    always_ff @(posedge wb_clk_i or negedge resetb) begin
        if (!resetb) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= io_in[37:18];
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_s       = r_sync[SYNC_STAGES-1];
    assign w_same    = (w_s == r_cand);
    // Count includes the sample being compared this cycle
    assign w_cnt_inc = {1'b0, r_cnt} + (W_CNT+1)'(1);
    assign w_settled = (w_cnt_inc >= STABLE_N);

    // Lane 0: A0=[3:0] B0=[7:4] SEL1=[17:16]; lane 1: A1=[11:8] B1=[15:12] SEL2=[19:18]
    assign w_r0 = lane_alu(r_cand[3:0],  r_cand[7:4],   r_cand[17:16]);
    assign w_r1 = lane_alu(r_cand[11:8], r_cand[15:12], r_cand[19:18]);

    // Settle / compute / hold sequencer with registered pad outputs
    always_ff @(posedge wb_clk_i or negedge resetb) begin
        if (!resetb) begin
            r_state <= ST_IDLE;
            r_cand  <= '0;
            r_cnt   <= '0;
            r_r0    <= '0;
            r_r1    <= '0;
            r_z0    <= 1'b0;
            r_z1    <= 1'b0;
            r_frm   <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cand  <= w_s;
                    r_cnt   <= W_CNT'(1);
                    r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (w_same) begin
                        if (r_cnt != CNT_MAX) begin
                            r_cnt <= r_cnt + W_CNT'(1);
                        end
                        if (w_settled) begin
                            r_state <= ST_COMPUTE;
                        end
                    end else begin
                        r_cand <= w_s;
                        r_cnt  <= W_CNT'(1);
                        // A single fresh sample already satisfies a depth of one
                        if (STABLE_CYCLES <= 1) begin
                            r_state <= ST_COMPUTE;
                        end
                    end
                end
                ST_COMPUTE: begin
                    r_r0    <= w_r0;
                    r_r1    <= w_r1;
                    r_z0    <= (w_r0 == '0);
                    r_z1    <= (w_r1 == '0);
                    r_frm   <= r_frm + W_FRM'(1);
                    r_valid <= 1'b1;
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!w_same) begin
                        r_cand  <= w_s;
                        r_cnt   <= W_CNT'(1);
                        r_valid <= 1'b0;
                        r_state <= ST_SETTLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_out = {20'b0, r_frm, r_z1, r_z0, r_r1, r_r0, 3'b000, r_valid};
    assign io_oeb = OEB_MAP;

endmodule

// File: tb/tb_macro_15_pad_alu_resp.sv
// Scoreboard bench for macro_15_pad_alu_resp: drives pad words, queues the
// expected frame for each, and compares when VALID rises.
module tb_macro_15_pad_alu_resp;

    logic        clk = 1'b0;
    logic        resetb;
    logic [37:0] io_in;
    logic [37:0] io_out;
    logic [37:0] io_oeb;

    localparam logic [37:0] OEB_EXP = 38'h3F_FFFC_000E;

    typedef struct {
        logic [4:0] r0;
        logic [4:0] r1;
        logic [1:0] f;
    } exp_t;

    exp_t        sb[$];
    int          n_err = 0;
    int          n_chk = 0;
    logic [1:0]  f_model;
    logic [37:0] held;

    macro_15_pad_alu_resp dut (
        .wb_clk_i (clk),
        .resetb   (resetb),
        .io_in    (io_in),
        .io_out   (io_out),
        .io_oeb   (io_oeb)
    );

    always #5 clk = ~clk;

    // Single comparison point
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] alu_model(input int a, input int b, input int sel);
        int v;
        case (sel)
            0:       v = a + b;
            1:       v = (a < b) ? (a - b + 32) : (a - b);
            2:       v = a & b;
            default: v = a ^ b;
        endcase
        return 5'(v);
    endfunction

    function automatic logic [37:0] compose(input logic [4:0] r0, input logic [4:0] r1,
                                            input logic [1:0] f, input logic v);
        logic [37:0] o;
        o        = '0;
        o[8:4]   = r0;
        o[13:9]  = r1;
        o[14]    = (r0 == 5'd0);
        o[15]    = (r1 == 5'd0);
        o[17:16] = f;
        o[0]     = v;
        return o;
    endfunction

    function automatic logic [19:0] mk(input int a0, input int b0, input int a1,
                                       input int b1, input int s1, input int s2);
        return {2'(s2), 2'(s1), 4'(b1), 4'(a1), 4'(b0), 4'(a0)};
    endfunction

    task automatic drive_word(input logic [19:0] w);
        io_in = {w, 18'($urandom)};
    endtask

    task automatic push_exp(input logic [19:0] w);
        exp_t e;
        e.r0    = alu_model(int'(w[3:0]),  int'(w[7:4]),   int'(w[17:16]));
        e.r1    = alu_model(int'(w[11:8]), int'(w[15:12]), int'(w[19:18]));
        f_model = f_model + 2'd1;
        e.f     = f_model;
        sb.push_back(e);
    endtask

    // Wait for VALID to (re)assert; lat/drop_k count clock edges since the call
    task automatic wait_frame(input string tag, output int lat, output int drop_k);
        bit   seen_low;
        exp_t e;
        seen_low = (io_out[0] == 1'b0);
        lat      = -1;
        drop_k   = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (!io_out[0] && !seen_low) begin
                seen_low = 1'b1;
                drop_k   = k;
            end else if (io_out[0] && seen_low) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            check_val({tag, " timeout"}, 64'd0, 64'd1);
        end else if (sb.size() == 0) begin
            check_val({tag, " sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check_val({tag, " io_out"}, io_out, compose(e.r0, e.r1, e.f, 1'b1));
            held = compose(e.r0, e.r1, e.f, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] w;
        logic [37:0] prev;
        int          lat;
        int          drop_k;

        resetb  = 1'b0;
        io_in   = {6'($urandom), $urandom};
        f_model = 2'd0;
        held    = '0;

        // T1: reset with random pads
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("t1 io_out", io_out, 64'd0);
            check_val("t1 io_oeb", io_oeb, OEB_EXP);
            io_in = {6'($urandom), $urandom};
        end

        // T2: add with carry, released together with the word
        w = mk(9, 9, 0, 0, 0, 0);
        drive_word(w);
        push_exp(w);
        resetb = 1'b1;
        wait_frame("t2", lat, drop_k);
        check_val("t2 latency", lat, 64'd7);
        check_val("t2 r0", io_out[8:4], 5'b10010);
        check_val("t2 r1", io_out[13:9], 5'b00000);
        check_val("t2 zflags", io_out[15:14], 2'b10);
        check_val("t2 frame", io_out[17:16], 2'b01);

        // T3: sub with borrow, AND, XOR (frame count wraps to 0)
        w = mk(3, 5, 0, 0, 1, 0);
        drive_word(w);
        push_exp(w);
        wait_frame("t3a", lat, drop_k);
        check_val("t3a r0", io_out[8:4], 5'b11110);
        check_val("t3a latency", lat, 64'd7);

        w = mk(3, 5, 12, 10, 1, 2);
        drive_word(w);
        push_exp(w);
        wait_frame("t3b", lat, drop_k);
        check_val("t3b r1", io_out[13:9], 5'b01000);

        w = mk(3, 5, 12, 10, 1, 3);
        drive_word(w);
        push_exp(w);
        wait_frame("t3c", lat, drop_k);
        check_val("t3c r1", io_out[13:9], 5'b00110);
        check_val("t3c frame", io_out[17:16], 2'b00);

        // T4: A0 toggling every 3 clocks never settles
        for (int t = 0; t < 13; t++) begin
            drive_word(mk((t % 2 == 0) ? 2 : 3, 5, 12, 10, 1, 3));
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                if (t > 0 || c == 3) begin
                    check_val("t4 valid low", io_out[0], 64'd0);
                    check_val("t4 held", io_out[17:1], held[17:1]);
                end
            end
        end
        w = mk(7, 5, 12, 10, 1, 3);
        drive_word(w);
        push_exp(w);
        wait_frame("t4 freeze", lat, drop_k);
        check_val("t4 latency", lat, 64'd7);
        check_val("t4 r0", io_out[8:4], 5'b00010);

        // T5: one-clock glitch on B1 while holding
        prev = io_out;
        drive_word(w ^ 20'h0_1000);
        @(negedge clk);
        drive_word(w);
        push_exp(w);
        wait_frame("t5", lat, drop_k);
        check_val("t5 drop within 3", (drop_k >= 1 && drop_k <= 2), 64'd1);
        check_val("t5 latency", lat, 64'd7);
        check_val("t5 same result", io_out[15:4], prev[15:4]);
        check_val("t5 frame inc", io_out[17:16], 2'(prev[17:16] + 2'd1));

        // T6: reset during settling, then clean re-acceptance
        w = mk(15, 1, 6, 6, 0, 1);
        drive_word(w);
        @(negedge clk);
        @(negedge clk);
        resetb = 1'b0;
        #1;
        check_val("t6 async clear", io_out, 64'd0);
        sb.delete();
        f_model = 2'd0;
        @(negedge clk);
        check_val("t6 in reset", io_out, 64'd0);
        @(negedge clk);
        resetb = 1'b1;
        push_exp(w);
        wait_frame("t6", lat, drop_k);
        check_val("t6 latency", lat, 64'd7);
        check_val("t6 frame", io_out[17:16], 2'b01);
        check_val("t6 r0", io_out[8:4], 5'b10000);
        check_val("t6 oeb", io_oeb, OEB_EXP);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
